// File: rtl/instruction_assembler_pkg.sv
// Shared definitions for the keypad instruction assembler and its consumers.
// Widths, key codes and the field/state encoding live here so that the
// downstream instruction decoder interprets the same layout.
package instr_pkg;

    localparam int FUNCT_WIDTH = 32'd3;
    localparam int IMM_WIDTH   = 32'd16;
    localparam int KEY_WIDTH   = 32'd5;
    localparam int INSTR_WIDTH = 32'd35;

    // Number of hex digits one immediate can hold, and a counter wide enough for it.
    localparam int DIGIT_CAP = IMM_WIDTH / 32'd4;
    localparam int CNT_WIDTH = $clog2(DIGIT_CAP + 32'd1);

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(32'd0);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(32'd1);
    localparam logic [CNT_WIDTH-1:0] CNT_CAP  = CNT_WIDTH'(DIGIT_CAP);

    // Key codes above the hex digits.
    localparam logic [KEY_WIDTH-1:0] KEY_ENTER = 5'h10;
    localparam logic [KEY_WIDTH-1:0] KEY_CLEAR = 5'h11;
    localparam logic [KEY_WIDTH-1:0] KEY_BACK  = 5'h12;

    // First hex digit that does not fit in the funct field.
    localparam logic [KEY_WIDTH-1:0] FUNCT_DIGIT_LIMIT = 5'h08;

    typedef enum logic [1:0] {
        FIELD_FUNCT = 2'd0,
        FIELD_IMMA  = 2'd1,
        FIELD_IMMB  = 2'd2,
        FIELD_ISSUE = 2'd3
    } field_e;

    // True for key codes 0x00-0x0F.
    function automatic logic is_hex_digit(input logic [KEY_WIDTH-1:0] code);
        return (code < 5'h10);
    endfunction

endpackage

// File: rtl/instruction_assembler_if.sv
// Keypad input and instruction output bundle of the instruction assembler.
// slave = the assembler, master = the keypad/downstream side driving it.
interface instruction_assembler_if;
    import instr_pkg::*;

    logic                   key_valid;
    logic [KEY_WIDTH-1:0]   key_code;
    logic                   key_ready;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [1:0]             entry_field;
    logic                   entry_error;

    modport master (
        output key_valid, key_code, instr_ready,
        input  key_ready, instruction, instr_valid, entry_field, entry_error
    );

    modport slave (
        input  key_valid, key_code, instr_ready,
        output key_ready, instruction, instr_valid, entry_field, entry_error
    );

endinterface

// File: rtl/instruction_assembler_hex_field_accum.sv
// One immediate field: a nibble shift register plus a digit counter.
// New digits enter at the least significant end. Overflow pulses in the
// same cycle as a push that finds the field already full.
// Backspace (pop) exists only when INSTR_BACKSPACE_EN is defined.
module hex_field_accum
    import instr_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic                 pop,
    input  logic                 clear,
    input  logic [3:0]           digit,
    output logic [IMM_WIDTH-1:0] value,
    output logic                 overflow
);

    logic [IMM_WIDTH-1:0] value_r;
    logic [CNT_WIDTH-1:0] count_r;
    logic                 full_s;

    assign full_s   = (count_r == CNT_CAP);
    assign overflow = push && full_s;
    assign value    = value_r;

`ifndef INSTR_BACKSPACE_EN
    logic unused_pop_s;
    assign unused_pop_s = pop;
`endif

    // Shift digits in on push; clear wipes the field; pop drops the newest digit.
    always_ff @(posedge clk) begin
        if (reset) begin
            value_r <= {IMM_WIDTH{1'b0}};
            count_r <= CNT_ZERO;
        end else if (clear) begin
            value_r <= {IMM_WIDTH{1'b0}};
            count_r <= CNT_ZERO;
        end else if (push && !full_s) begin
            value_r <= {value_r[IMM_WIDTH-5:0], digit};
            count_r <= count_r + CNT_ONE;
`ifdef INSTR_BACKSPACE_EN
        end else if (pop && (count_r != CNT_ZERO)) begin
            value_r <= value_r >> 32'd4;
            count_r <= count_r - CNT_ONE;
`endif
        end else begin
            value_r <= value_r;
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/instruction_assembler.sv
// Keypad instruction assembler: collects one funct digit and two hex
// immediates from serial key presses and holds the finished 35-bit
// instruction {funct, immA, immB} under a valid/ready handshake.
// Optional build macro: INSTR_BACKSPACE_EN enables the BACK key (0x12);
// without it 0x12 is accepted and ignored like any unknown code.
module instruction_assembler
    import instr_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    instruction_assembler_if.slave  bus
);

    field_e                 state_r;
    field_e                 state_next_s;
    logic [FUNCT_WIDTH-1:0] funct_r;
    logic [FUNCT_WIDTH-1:0] funct_next_s;
    logic                   entry_error_r;
    logic                   instr_valid_r;
    logic                   key_ready_r;

    logic                   key_acc_s;
    logic                   is_digit_s;
    logic                   err_set_s;
    logic                   err_clr_s;
    logic                   fields_clr_s;
    logic                   a_push_s;
    logic                   a_pop_s;
    logic                   b_push_s;
    logic                   b_pop_s;
    logic                   a_ovf_s;
    logic                   b_ovf_s;
    logic [IMM_WIDTH-1:0]   imm_a_s;
    logic [IMM_WIDTH-1:0]   imm_b_s;

    assign key_acc_s  = bus.key_valid && key_ready_r;
    assign is_digit_s = is_hex_digit(bus.key_code);

    hex_field_accum u_imm_a (
        .clk      (clk),
        .reset    (reset),
        .push     (a_push_s),
        .pop      (a_pop_s),
        .clear    (fields_clr_s),
        .digit    (bus.key_code[3:0]),
        .value    (imm_a_s),
        .overflow (a_ovf_s)
    );

    hex_field_accum u_imm_b (
        .clk      (clk),
        .reset    (reset),
        .push     (b_push_s),
        .pop      (b_pop_s),
        .clear    (fields_clr_s),
        .digit    (bus.key_code[3:0]),
        .value    (imm_b_s),
        .overflow (b_ovf_s)
    );

    // Decode the accepted key (or the issue handshake) into next state and field controls.
    always_comb begin
        state_next_s = state_r;
        funct_next_s = funct_r;
        err_set_s    = 1'b0;
        err_clr_s    = 1'b0;
        fields_clr_s = 1'b0;
        a_push_s     = 1'b0;
        a_pop_s      = 1'b0;
        b_push_s     = 1'b0;
        b_pop_s      = 1'b0;

        if (state_r == FIELD_ISSUE) begin
            if (bus.instr_ready) begin
                state_next_s = FIELD_FUNCT;
                funct_next_s = {FUNCT_WIDTH{1'b0}};
                fields_clr_s = 1'b1;
                err_clr_s    = 1'b1;
            end else begin
                state_next_s = FIELD_ISSUE;
            end
        end else if (key_acc_s) begin
            if (bus.key_code == KEY_CLEAR) begin
                state_next_s = FIELD_FUNCT;
                funct_next_s = {FUNCT_WIDTH{1'b0}};
                fields_clr_s = 1'b1;
                err_clr_s    = 1'b1;
            end else begin
                case (state_r)
                    FIELD_FUNCT: begin
                        if (is_digit_s) begin
                            if (bus.key_code < FUNCT_DIGIT_LIMIT) begin
                                funct_next_s = bus.key_code[FUNCT_WIDTH-1:0];
                            end else begin
                                err_set_s = 1'b1;
                            end
                        end else if (bus.key_code == KEY_ENTER) begin
                            state_next_s = FIELD_IMMA;
`ifdef INSTR_BACKSPACE_EN
                        end else if (bus.key_code == KEY_BACK) begin
                            funct_next_s = {FUNCT_WIDTH{1'b0}};
`endif
                        end else begin
                            state_next_s = state_r;
                        end
                    end
                    FIELD_IMMA: begin
                        if (is_digit_s) begin
                            a_push_s = 1'b1;
                        end else if (bus.key_code == KEY_ENTER) begin
                            state_next_s = FIELD_IMMB;
`ifdef INSTR_BACKSPACE_EN
                        end else if (bus.key_code == KEY_BACK) begin
                            a_pop_s = 1'b1;
`endif
                        end else begin
                            state_next_s = state_r;
                        end
                    end
                    FIELD_IMMB: begin
                        if (is_digit_s) begin
                            b_push_s = 1'b1;
                        end else if (bus.key_code == KEY_ENTER) begin
                            state_next_s = FIELD_ISSUE;
`ifdef INSTR_BACKSPACE_EN
                        end else if (bus.key_code == KEY_BACK) begin
                            b_pop_s = 1'b1;
`endif
                        end else begin
                            state_next_s = state_r;
                        end
                    end
                    default: begin
                        state_next_s = state_r;
                    end
                endcase
            end
        end else begin
            state_next_s = state_r;
        end

        // A digit pushed into a full immediate also flags an entry error.
        err_set_s = err_set_s | a_ovf_s | b_ovf_s;
    end

    // State, funct, sticky error and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= FIELD_FUNCT;
            funct_r       <= {FUNCT_WIDTH{1'b0}};
            entry_error_r <= 1'b0;
            instr_valid_r <= 1'b0;
            key_ready_r   <= 1'b1;
        end else begin
            state_r       <= state_next_s;
            funct_r       <= funct_next_s;
            instr_valid_r <= (state_next_s == FIELD_ISSUE);
            key_ready_r   <= (state_next_s != FIELD_ISSUE);
            if (err_clr_s) begin
                entry_error_r <= 1'b0;
            end else if (err_set_s) begin
                entry_error_r <= 1'b1;
            end else begin
                entry_error_r <= entry_error_r;
            end
        end
    end

    assign bus.key_ready   = key_ready_r;
    assign bus.instr_valid = instr_valid_r;
    assign bus.entry_error = entry_error_r;
    assign bus.entry_field = state_r;
    assign bus.instruction = {funct_r, imm_a_s, imm_b_s};

endmodule

// File: tb/tb_instruction_assembler.sv
// Self-checking bench for instruction_assembler: a table of directed
// vectors, hand-written corner sequences, then random keys compared each
// cycle against a digit-list model of the keypad entry rules.
module tb_instruction_assembler;

    localparam logic [4:0] K_ENT = 5'h10;
    localparam logic [4:0] K_CLR = 5'h11;
    localparam logic [4:0] K_BK  = 5'h12;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    instruction_assembler_if bus();

    instruction_assembler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: fields as lists of entered digits.
    int         m_field;
    int         m_funct;
    int         m_a[$];
    int         m_b[$];
    bit         m_err;

    typedef struct {
        logic        kv;
        logic [4:0]  kc;
        logic        ir;
        logic        e_valid;
        logic        e_kready;
        logic [1:0]  e_field;
        logic        e_err;
        logic [34:0] e_instr;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic kv, input logic [4:0] kc, input logic ir,
                                input logic ev, input logic ek, input logic [1:0] ef,
                                input logic ee, input logic [34:0] ei);
        vec_t v;
        v.kv = kv; v.kc = kc; v.ir = ir; v.e_valid = ev; v.e_kready = ek;
        v.e_field = ef; v.e_err = ee; v.e_instr = ei;
        return v;
    endfunction

    task automatic check(input string nm, input logic [34:0] act, input logic [34:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_field = 0;
        m_funct = 0;
        m_a.delete();
        m_b.delete();
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic kv, input logic [4:0] kc, input logic ir, input logic rs);
        int code;
        code = int'(kc);
        if (rs) begin
            model_clear();
        end else if (m_field == 3) begin
            if (ir) model_clear();
        end else if (kv) begin
            if (code == 17) begin
                model_clear();
            end else if (code < 16) begin
                if (m_field == 0) begin
                    if (code < 8) m_funct = code;
                    else m_err = 1'b1;
                end else if (m_field == 1) begin
                    if (m_a.size() < 4) m_a.push_back(code);
                    else m_err = 1'b1;
                end else begin
                    if (m_b.size() < 4) m_b.push_back(code);
                    else m_err = 1'b1;
                end
            end else if (code == 16) begin
                m_field = m_field + 1;
            end else if (code == 18) begin
`ifdef INSTR_BACKSPACE_EN
                if (m_field == 0) m_funct = 0;
                else if (m_field == 1 && m_a.size() > 0) void'(m_a.pop_back());
                else if (m_field == 2 && m_b.size() > 0) void'(m_b.pop_back());
`endif
            end
        end
    endtask

    task automatic compare_model();
        int va;
        int vb;
        logic [34:0] ei;
        va = 0;
        vb = 0;
        foreach (m_a[i]) va = va * 16 + m_a[i];
        foreach (m_b[i]) vb = vb * 16 + m_b[i];
        ei = {m_funct[2:0], va[15:0], vb[15:0]};
        check("model_instr_valid", 35'(bus.instr_valid), 35'(m_field == 3));
        check("model_key_ready", 35'(bus.key_ready), 35'(m_field != 3));
        check("model_entry_field", 35'(bus.entry_field), 35'(m_field));
        check("model_entry_error", 35'(bus.entry_error), 35'(m_err));
        check("model_instruction", bus.instruction, ei);
    endtask

    // Drive one cycle of inputs at the falling edge, compare after the next falling edge.
    task automatic cycle(input logic kv, input logic [4:0] kc, input logic ir, input logic rs);
        bus.key_valid   = kv;
        bus.key_code    = kc;
        bus.instr_ready = ir;
        reset           = rs;
        model_step(kv, kc, ir, rs);
        @(posedge clk);
        @(negedge clk);
        compare_model();
    endtask

    task automatic key(input logic [4:0] kc);
        cycle(1'b1, kc, 1'b0, 1'b0);
    endtask

    initial begin
        logic [4:0] kc;
        logic       kv;
        logic       ir;
        logic       rs;
        int         r;

        errors = 0;
        checks = 0;
        bus.key_valid   = 1'b0;
        bus.key_code    = 5'h00;
        bus.instr_ready = 1'b0;
        reset           = 1'b1;
        model_clear();
        @(negedge clk);
        cycle(1'b0, 5'h00, 1'b0, 1'b1);
        cycle(1'b0, 5'h00, 1'b0, 1'b1);

        // Reset state.
        check("reset_instr_valid", 35'(bus.instr_valid), 35'd0);
        check("reset_key_ready", 35'(bus.key_ready), 35'd1);
        check("reset_entry_error", 35'(bus.entry_error), 35'd0);
        check("reset_entry_field", 35'(bus.entry_field), 35'd0);
        check("reset_instruction", bus.instruction, 35'd0);

        // Directed entry, stalled issue with an ignored key, then handshake.
        tbl.push_back(mk(1'b1, 5'h03, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 35'h3_0000_0000));
        tbl.push_back(mk(1'b1, K_ENT, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 35'h3_0000_0000));
        tbl.push_back(mk(1'b1, 5'h01, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 35'h3_0001_0000));
        tbl.push_back(mk(1'b1, 5'h02, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 35'h3_0012_0000));
        tbl.push_back(mk(1'b1, 5'h0A, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 35'h3_012A_0000));
        tbl.push_back(mk(1'b1, 5'h0B, 1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 35'h3_12AB_0000));
        tbl.push_back(mk(1'b1, K_ENT, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 35'h3_12AB_0000));
        tbl.push_back(mk(1'b1, 5'h00, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 35'h3_12AB_0000));
        tbl.push_back(mk(1'b1, 5'h00, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 35'h3_12AB_0000));
        tbl.push_back(mk(1'b1, 5'h0F, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 35'h3_12AB_000F));
        tbl.push_back(mk(1'b1, 5'h0F, 1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 35'h3_12AB_00FF));
        tbl.push_back(mk(1'b1, K_ENT, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 35'h3_12AB_00FF));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1'b1, 5'h05, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 35'h3_12AB_00FF));
        tbl.push_back(mk(1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 35'h0));
        tbl.push_back(mk(1'b0, 5'h00, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 35'h0));

        foreach (tbl[i]) begin
            cycle(tbl[i].kv, tbl[i].kc, tbl[i].ir, 1'b0);
            check($sformatf("vec%0d_valid", i), 35'(bus.instr_valid), 35'(tbl[i].e_valid));
            check($sformatf("vec%0d_key_ready", i), 35'(bus.key_ready), 35'(tbl[i].e_kready));
            check($sformatf("vec%0d_field", i), 35'(bus.entry_field), 35'(tbl[i].e_field));
            check($sformatf("vec%0d_error", i), 35'(bus.entry_error), 35'(tbl[i].e_err));
            check($sformatf("vec%0d_instr", i), bus.instruction, tbl[i].e_instr);
        end

        // Out-of-range funct digit: error flagged, zero instruction still issues.
        key(5'h09);
        key(K_ENT);
        key(K_ENT);
        key(K_ENT);
        check("badfunct_valid", 35'(bus.instr_valid), 35'd1);
        check("badfunct_error", 35'(bus.entry_error), 35'd1);
        check("badfunct_instr", bus.instruction, 35'h0);
        cycle(1'b0, 5'h00, 1'b1, 1'b0);
        check("badfunct_err_cleared", 35'(bus.entry_error), 35'd0);

        // Fifth immA digit overflows.
        key(K_ENT);
        key(5'h01); key(5'h02); key(5'h03); key(5'h04); key(5'h05);
        check("ovf_imma", 35'(bus.instruction[31:16]), 35'h1234);
        check("ovf_error", 35'(bus.entry_error), 35'd1);
`ifdef INSTR_BACKSPACE_EN
        key(K_BK); key(K_BK); key(5'h07);
        check("back_imma", 35'(bus.instruction[31:16]), 35'h0127);
`else
        key(K_CLR);
        key(K_ENT);
        key(5'h0A); key(5'h0B); key(K_BK); key(5'h0C);
        check("noback_imma", 35'(bus.instruction[31:16]), 35'h0ABC);
`endif

        // CLEAR in the middle of immB.
        key(K_ENT);
        key(5'h04);
        key(K_CLR);
        check("clear_field", 35'(bus.entry_field), 35'd0);
        check("clear_instr", bus.instruction, 35'h0);
        check("clear_error", 35'(bus.entry_error), 35'd0);

        // Reset while an instruction is waiting.
        key(5'h06); key(K_ENT); key(5'h01); key(K_ENT); key(K_ENT);
        check("pre_reset_valid", 35'(bus.instr_valid), 35'd1);
        cycle(1'b0, 5'h00, 1'b0, 1'b1);
        check("issue_reset_valid", 35'(bus.instr_valid), 35'd0);
        check("issue_reset_key_ready", 35'(bus.key_ready), 35'd1);
        check("issue_reset_instr", bus.instruction, 35'h0);

        // Random keys against the model.
        for (int n = 0; n < 3000; n++) begin
            rs = ($urandom_range(0, 199) == 0);
            kv = ($urandom_range(0, 3) != 0);
            ir = ($urandom_range(0, 2) == 0);
            r  = $urandom_range(0, 99);
            if (r < 60)      kc = 5'($urandom_range(0, 15));
            else if (r < 80) kc = K_ENT;
            else if (r < 85) kc = K_CLR;
            else if (r < 93) kc = K_BK;
            else             kc = 5'($urandom_range(19, 31));
            cycle(kv, kc, ir, rs);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
